// File: rtl/digit_pkg.sv
// Shared types, seven-segment constants and the segment lookup
// used by the digit chain and its display driver.
package digit_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input bcd_t v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-N digit stage with up/down stepping, clear, saturating load
// and a combinational wrap flag that enables the next stage.
module mod_digit
  import digit_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  bcd_t modulus,
  input  logic en,
  input  logic down,
  input  logic clear,
  input  logic load,
  input  bcd_t d_in,
  output bcd_t q,
  output logic wrap_out
);

  bcd_t max_val;
  logic at_boundary;

  assign max_val     = modulus - 4'd1;
  assign at_boundary = down ? (q == 4'd0) : (q == max_val);
  assign wrap_out    = en & at_boundary;

  // Out-of-range preset nibbles clamp to the digit's maximum
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= (d_in > max_val) ? max_val : d_in;
    end else if (en) begin
      if (at_boundary) begin
        q <= down ? max_val : 4'd0;
      end else begin
        q <= down ? (q - 4'd1) : (q + 4'd1);
      end
    end
  end

endmodule

// File: rtl/digit_chain_display.sv
// Cascaded modulo-N digit counter with prescaled enable and terminal carry,
// driving a multiplexed active-low seven-segment display.
module digit_chain_display
  import digit_pkg::*;
#(
  parameter int                   NDIGITS  = 4,
  parameter logic [4*NDIGITS-1:0] MOD      = 16'h6A6A,
  parameter int                   TICK_DIV = 50_000_000,
  parameter int                   SCAN_DIV = 50_000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ativador,
  input  logic                   down,
  input  logic                   clear,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_value,
  input  logic                   blank_lz,
  output logic [4*NDIGITS-1:0]   digits,
  output logic                   clockOut,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          chain_wrap;

  assign tick = ativador & (presc == PRESC_LAST);

  // Prescaler freezes while disabled so a paused interval resumes intact
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (ativador) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    logic en;
    logic wrap;
    bcd_t q;

    if (i == 0) begin : g_first
      assign en = tick;
    end else begin : g_next
      assign en = tick & g_digit[i-1].wrap;
    end

    mod_digit u_digit (
      .clock    (clock),
      .reset_n  (reset_n),
      .modulus  (MOD[4*i +: 4]),
      .en       (en),
      .down     (down),
      .clear    (clear),
      .load     (load),
      .d_in     (load_value[4*i +: 4]),
      .q        (q),
      .wrap_out (wrap)
    );

    assign digits[4*i +: 4] = q;
  end

  assign chain_wrap = g_digit[NDIGITS-1].wrap;

  // Registered so the pulse lines up with the first cycle showing the wrapped value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clockOut <= 1'b0;
    end else begin
      clockOut <= chain_wrap & ~clear & ~load;
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  logic [NDIGITS-1:0] zero_hi;
  logic               all_zero;
  bcd_t               cur_digit;
  logic               blank_now;
  logic [6:0]         seg_next;
  logic [NDIGITS-1:0] an_next;

  // zero_hi[i] is set when digit i and everything above it read zero
  always_comb begin
    zero_hi  = '0;
    all_zero = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (digits[4*i +: 4] == 4'd0);
      zero_hi[i] = all_zero;
    end
    cur_digit = digits[4*scan_idx +: 4];
    blank_now = blank_lz & (scan_idx != '0) & zero_hi[scan_idx];
    seg_next  = blank_now ? SEG_BLANK : seg7(cur_digit);
    an_next   = ~(NDIGITS'(1) << scan_idx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_0;
      an  <= ~NDIGITS'(1);
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
